// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port RV32I integer register file.
package reg_file_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);
    localparam int ZERO_REG = 0;

    typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between decode/writeback and reg_file_mp: read ports, write ports, reserve port, busy map.
interface reg_file_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int NWP  = 2
);
    localparam int AW = $clog2(NREG);

    // rs_en[p] is a one-cycle request with no back-pressure; rs_valid[p] qualifies
    // rs_data[p]/rs_busy[p] exactly one edge later and is never stalled.
    logic [NRP*AW-1:0]   rs_addr;
    logic [NRP-1:0]      rs_en;
    logic [NRP*XLEN-1:0] rs_data;
    logic [NRP-1:0]      rs_valid;
    logic [NRP-1:0]      rs_busy;
    logic [NWP*AW-1:0]   rd_addr;
    logic [NWP-1:0]      rd_en;
    logic [NWP*XLEN-1:0] rd_data;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_en;
    logic [NREG-1:0]     busy;

    modport master (
        output rs_addr, rs_en, rd_addr, rd_en, rd_data, rsv_addr, rsv_en,
        input  rs_data, rs_valid, rs_busy, busy
    );

    modport slave (
        input  rs_addr, rs_en, rd_addr, rd_en, rd_data, rsv_addr, rsv_en,
        output rs_data, rs_valid, rs_busy, busy
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Busy bitmap for in-flight producers: reserve sets, write releases, reserve wins a tie.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWP  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NWP*$clog2(NREG)-1:0]   rd_addr,
    input  logic [NWP-1:0]                rd_en,
    input  logic [$clog2(NREG)-1:0]       rsv_addr,
    input  logic                          rsv_en,
    output logic [NREG-1:0]               busy
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    // Releases first, then the reserve, so a new producer overrides a retiring one.
    always_comb begin
        busy_nxt = busy_q;
        for (int w = 0; w < NWP; w++) begin
            if (rd_en[w] && rd_addr[w*AW +: AW] != AW'(ZERO_REG)) begin
                busy_nxt[rd_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != AW'(ZERO_REG)) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy = busy_q;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRP registered read ports, NWP prioritised write ports, busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes (data and busy release) to the read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = 2,
    parameter int NWP  = 2
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs    [NREG];
    logic [AW-1:0]   wr_addr [NWP];
    logic [XLEN-1:0] wr_data [NWP];
    logic [NREG-1:0] busy_map;

    for (genvar w = 0; w < NWP; w++) begin : g_wr
        assign wr_addr[w] = bus.rd_addr[w*AW +: AW];
        assign wr_data[w] = bus.rd_data[w*XLEN +: XLEN];
    end

    // Later ports are applied last, so the highest index wins an address conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (bus.rd_en[w] && wr_addr[w] != AW'(ZERO_REG)) begin
                    regs[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    reg_file_scoreboard #(
        .NREG (NREG),
        .NWP  (NWP)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (bus.rd_addr),
        .rd_en    (bus.rd_en),
        .rsv_addr (bus.rsv_addr),
        .rsv_en   (bus.rsv_en),
        .busy     (busy_map)
    );

    assign bus.busy = busy_map;

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] nxt_data;
        logic [XLEN-1:0] data_q;
        logic            nxt_busy;
        logic            busy_q;
        logic            valid_q;

        assign ra = bus.rs_addr[p*AW +: AW];

        always_comb begin
            nxt_data = regs[ra];
            nxt_busy = busy_map[ra];
`ifdef REG_FILE_BYPASS_EN
            // A matching write retires its producer, so the forwarded busy is 0.
            for (int w = 0; w < NWP; w++) begin
                if (bus.rd_en[w] && wr_addr[w] != AW'(ZERO_REG) && wr_addr[w] == ra) begin
                    nxt_data = wr_data[w];
                    nxt_busy = 1'b0;
                end
            end
`endif
            if (!bus.rs_en[p]) begin
                nxt_data = '0;
                nxt_busy = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= nxt_data;
                busy_q  <= nxt_busy;
                valid_q <= bus.rs_en[p];
            end
        end

        assign bus.rs_data[p*XLEN +: XLEN] = data_q;
        assign bus.rs_busy[p]              = busy_q;
        assign bus.rs_valid[p]             = valid_q;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: spec-level model checked every cycle plus directed literal checks.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int NWP  = 2;
    localparam int AW   = $clog2(NREG);
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus ();

    reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [XLEN-1:0] m_regs [NREG];
    logic [NREG-1:0] m_busy = '0;
    logic [XLEN-1:0] exp_data [NRP];
    logic [NRP-1:0]  exp_valid = '0;
    logic [NRP-1:0]  exp_rbusy = '0;

    initial begin
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        for (int p = 0; p < NRP; p++) exp_data[p] = '0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_busy = '0;
            for (int p = 0; p < NRP; p++) exp_data[p] = '0;
            exp_valid = '0;
            exp_rbusy = '0;
        end else begin
            for (int p = 0; p < NRP; p++) begin
                int a;
                a = int'(bus.rs_addr[p*AW +: AW]);
                exp_valid[p] = bus.rs_en[p];
                exp_data[p]  = '0;
                exp_rbusy[p] = 1'b0;
                if (bus.rs_en[p]) begin
                    exp_data[p]  = (a == 0) ? '0 : m_regs[a];
                    exp_rbusy[p] = (a == 0) ? 1'b0 : m_busy[a];
                    if (BYP) begin
                        for (int w = 0; w < NWP; w++) begin
                            if (bus.rd_en[w] && a != 0 && int'(bus.rd_addr[w*AW +: AW]) == a) begin
                                exp_data[p]  = bus.rd_data[w*XLEN +: XLEN];
                                exp_rbusy[p] = 1'b0;
                            end
                        end
                    end
                end
            end
            for (int w = 0; w < NWP; w++) begin
                int a;
                a = int'(bus.rd_addr[w*AW +: AW]);
                if (bus.rd_en[w] && a != 0) begin
                    m_regs[a] = bus.rd_data[w*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (bus.rsv_en && bus.rsv_addr != '0) m_busy[bus.rsv_addr] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < NRP; p++) begin
                check("model_rs_data", bus.rs_data[p*XLEN +: XLEN], exp_data[p]);
                check("model_rs_valid", XLEN'(bus.rs_valid[p]), XLEN'(exp_valid[p]));
                check("model_rs_busy", XLEN'(bus.rs_busy[p]), XLEN'(exp_rbusy[p]));
            end
            check("model_busy", bus.busy, m_busy);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_in();
        bus.rs_addr  = '0;
        bus.rs_en    = '0;
        bus.rd_addr  = '0;
        bus.rd_en    = '0;
        bus.rd_data  = '0;
        bus.rsv_addr = '0;
        bus.rsv_en   = 1'b0;
    endtask

    task automatic set_wr(input int port, input reg_addr_t a, input logic [XLEN-1:0] d);
        bus.rd_addr[port*AW +: AW]   = a;
        bus.rd_data[port*XLEN +: XLEN] = d;
        bus.rd_en[port]              = 1'b1;
    endtask

    task automatic set_rd(input int port, input reg_addr_t a);
        bus.rs_addr[port*AW +: AW] = a;
        bus.rs_en[port]            = 1'b1;
    endtask

    task automatic reserve(input reg_addr_t a);
        bus.rsv_addr = a;
        bus.rsv_en   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        clear_in();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", bus.busy, '0);
        check("reset_valid", XLEN'(bus.rs_valid), '0);

        for (int i = 1; i < 16; i++) begin
            clear_in();
            set_wr(i % 2, reg_addr_t'(i), 32'(i) * 32'h0101_0101);
            set_rd(0, reg_addr_t'(i - 1));
            set_rd(1, reg_addr_t'(i));
            tick();
        end

        clear_in(); set_wr(0, 5'd7, 32'hDEAD_BEEF); tick();
        clear_in(); set_rd(0, 5'd7); bus.rs_addr[1*AW +: AW] = 5'd7; tick();
        check("x7_read", bus.rs_data[0 +: XLEN], 32'hDEAD_BEEF);
        check("x7_valid", XLEN'(bus.rs_valid[0]), 32'd1);
        check("dis_data", bus.rs_data[XLEN +: XLEN], '0);
        check("dis_valid", XLEN'(bus.rs_valid[1]), '0);
        check("dis_busy", XLEN'(bus.rs_busy[1]), '0);

        clear_in(); set_wr(1, 5'd0, 32'h1234_5678); tick();
        clear_in(); set_rd(0, 5'd0); tick();
        check("x0_read", bus.rs_data[0 +: XLEN], '0);

        clear_in(); set_wr(0, 5'd3, 32'h11); set_wr(1, 5'd3, 32'h22); tick();
        clear_in(); set_rd(0, 5'd3); set_rd(1, 5'd3); tick();
        check("conflict_p0", bus.rs_data[0 +: XLEN], 32'h22);
        check("conflict_p1", bus.rs_data[XLEN +: XLEN], 32'h22);

        clear_in(); set_wr(0, 5'd9, 32'hA); tick();
        clear_in(); set_wr(0, 5'd9, 32'hB); set_rd(0, 5'd9); tick();
        check("bypass_read", bus.rs_data[0 +: XLEN], BYP ? 32'hB : 32'hA);
        clear_in(); set_rd(0, 5'd9); tick();
        check("after_bypass", bus.rs_data[0 +: XLEN], 32'hB);

        clear_in(); reserve(5'd4); tick();
        check("rsv_busy4", XLEN'(bus.busy[4]), 32'd1);
        clear_in(); set_rd(1, 5'd4); tick();
        check("rsv_rs_busy", XLEN'(bus.rs_busy[1]), 32'd1);
        clear_in(); set_wr(1, 5'd4, 32'h44); tick();
        check("release_busy4", XLEN'(bus.busy[4]), '0);
        clear_in(); reserve(5'd4); set_wr(0, 5'd4, 32'h45); tick();
        check("rsv_and_rel", XLEN'(bus.busy[4]), 32'd1);
        clear_in(); reserve(5'd0); tick();
        check("rsv_x0", XLEN'(bus.busy[0]), '0);
        clear_in(); set_wr(0, 5'd4, 32'h46); set_rd(1, 5'd4); tick();
        check("byp_rs_busy", XLEN'(bus.rs_busy[1]), BYP ? 32'd0 : 32'd1);
        check("byp_rs_data", bus.rs_data[XLEN +: XLEN], BYP ? 32'h46 : 32'h45);

        clear_in(); reserve(5'd6); set_rd(0, 5'd5); set_rd(1, 5'd6); tick();
        check("pre_rst_x5", bus.rs_data[0 +: XLEN], 32'h0505_0505);
        clear_in(); set_wr(0, 5'd5, 32'h55); reserve(5'd8); set_rd(0, 5'd5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", XLEN'(bus.rs_valid), '0);
        check("async_rst_busy", bus.busy, '0);
        check("async_rst_data", bus.rs_data[0 +: XLEN], '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_in(); set_rd(0, 5'd5); set_rd(1, 5'd5); tick();
        check("rst_x5_p0", bus.rs_data[0 +: XLEN], '0);
        check("rst_x5_p1", bus.rs_data[XLEN +: XLEN], '0);
        check("rst_valid", XLEN'(bus.rs_valid), 32'd3);
        check("rst_busy_all", bus.busy, '0);

        clear_in(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the RV32I core, the successor to the single-write/dual-read file. Provides NRP registered read ports, NWP write ports with fixed priority, a per-register busy scoreboard for in-flight producers, and optional same-cycle write-to-read bypass. Sits between decode (reads, reservations) and writeback (writes, releases).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, at least 2
- NRP, 2, number of read ports, 1..4
- NWP, 2, number of write ports, 1..2
- AW, $clog2(NREG), address width; derived, not overridden

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- rs_addr  in  NRP*AW  read addresses; port p uses bits [p*AW +: AW]
- rs_en  in  NRP  read enables
- rs_data  out  NRP*XLEN  registered read data
- rs_valid  out  NRP  registered copy of rs_en
- rs_busy  out  NRP  registered busy state of the register read
- rd_addr  in  NWP*AW  write addresses
- rd_en  in  NWP  write enables; each write also releases the register's busy bit
- rd_data  in  NWP*XLEN  write data
- rsv_addr  in  AW  scoreboard reserve address
- rsv_en  in  1  set busy on rsv_addr
- busy  out  NREG  current scoreboard bitmap

## Operation
- Register 0 is hardwired zero: writes ignored, never busy, always reads 0.
- Write: on an edge with rd_en[w] set and rd_addr[w] nonzero, the register loads rd_data[w].
- Two writes to the same address in one cycle: the higher-index port wins.
- Read: on each edge, port p loads rs_data[p] with the value of register rs_addr[p] if rs_en[p] is set, otherwise 0. rs_valid[p] follows rs_en[p]. rs_busy[p] carries the busy bit of the addressed register, or 0 when disabled.
- Scoreboard: rsv_en sets busy[rsv_addr]; a write to an address clears its busy bit.
- Reserve and release of the same register in one cycle: busy ends at 1, so the new producer takes priority.
- Reserve of an already-busy register: busy stays 1. The block does not count producers.
- Reserve or write to address 0: no effect on busy.

## Timing
- Read latency is 1 cycle: address at edge N gives data valid after edge N.
- Write latency is 1 cycle: data is visible in the array after the edge.
- Same-cycle read and write of the same address: behaviour depends on the bypass macro (see Configuration).
- rs_busy uses the same bypass rule as data. A releasing write to the read address yields rs_busy 0 with bypass and the old busy state without it. A same-cycle reserve is not forwarded.
- Reset, asynchronous: all registers, busy, rs_data, rs_valid and rs_busy go to 0 immediately and stay 0 while reset is high.
- Reset mid-operation: pending writes and reservations in that cycle are discarded.
- First edge after reset deassertion behaves as a normal cycle.

## Configuration
- REG_FILE_BYPASS_EN defined: a read that matches an active same-cycle write (nonzero address) returns the new rd_data, using the highest-priority matching write port. rs_busy returns 0 in that case.
- REG_FILE_BYPASS_EN undefined: the read returns the pre-write array value and the pre-write busy bit. Decode must then stall one cycle on a writeback hazard.

## Structure
- The shared package reg_file_pkg holds:
  - XLEN_DEF, NREG_DEF
  - the typedef for a register address (logic [AW-1:0] for the default NREG)
  - the localparam ZERO_REG = 0
- Sub-module reg_file_scoreboard (parameters NREG, NWP) holds the busy bitmap, with reserve/release resolution and async reset. The top instantiates it once.
- The data array and read ports live in the top.

## Test plan
- Reset then read: assert reset mid-run with registers loaded, then read x5 on both ports after release -> rs_data 0, rs_valid 1, busy all 0.
- Write/read with x0: write 0xDEADBEEF to x7 on port 0, then read x7 next cycle -> 0xDEADBEEF. Write to x0, then read x0 -> 0.
- Dual-write conflict: port 0 writes x3=0x11 and port 1 writes x3=0x22 in the same cycle -> x3 reads 0x22.
- Bypass: x9=0xA, then in one cycle write x9=0xB while reading x9 -> 0xB with REG_FILE_BYPASS_EN, 0xA without it. The following read gives 0xB in both builds.
- Scoreboard: reserve x4 -> busy[4]=1 and a read of x4 gives rs_busy 1. Write x4 -> busy[4]=0. Reserve and write x4 in the same cycle -> busy[4]=1. Reserve x0 -> busy[0] stays 0.
- Disabled read: rs_en[1]=0 with rs_addr[1]=x7 holding 0xDEADBEEF -> rs_data[1]=0, rs_valid[1]=0, rs_busy[1]=0.
